// File: rtl/disco_mem_arbiter.sv
// Arbitrates the single disco program/data memory between instruction fetch and
// load/store, sequencing a fixed-latency read pipeline behind a req/ack handshake.
module disco_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [15:0]       if_rdata,
    output logic              if_ack,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [15:0]       ls_wdata,
    output logic [15:0]       ls_rdata,
    output logic              ls_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              owner_ls
);

    localparam logic [2:0] STREAK_MAX = 3'(STARVE_MAX);
    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic [2:0] lat_cnt;
    logic [2:0] streak;
    logic       pick_ls;
    logic       pick_if;

    // LS wins unless IF has already been passed over STARVE_MAX times in a row.
    assign pick_ls = ls_req && !(if_req && (streak == STREAK_MAX));
    assign pick_if = if_req && !pick_ls;
    assign busy    = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            streak    <= '0;
            owner_ls  <= 1'b0;
            if_rdata  <= '0;
            if_ack    <= 1'b0;
            ls_rdata  <= '0;
            ls_ack    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!if_req)
                        streak <= '0;
                    if (pick_ls) begin
                        owner_ls  <= 1'b1;
                        if (if_req && (streak != STREAK_MAX))
                            streak <= streak + 3'd1;
                        mem_we    <= ls_we;
                        mem_be    <= ls_we ? ls_be : 2'b11;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        // A store with no byte lanes touches nothing; acknowledge it directly.
                        if (ls_we && (ls_be == 2'b00)) begin
                            ls_ack <= 1'b1;
                            state  <= RESP;
                        end else begin
                            mem_en <= 1'b1;
                            state  <= ISSUE;
                        end
                    end else if (pick_if) begin
                        owner_ls <= 1'b0;
                        streak   <= '0;
                        mem_we   <= 1'b0;
                        mem_be   <= 2'b11;
                        mem_addr <= if_addr;
                        mem_en   <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    if (mem_we) begin
                        ls_ack <= 1'b1;
                        state  <= RESP;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        if (owner_ls) begin
                            ls_rdata <= mem_rdata;
                            ls_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    // Requests are deliberately ignored here so a just-acked req is not re-granted.
                    if_ack <= 1'b0;
                    ls_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disco_mem_arbiter.sv
// Randomized bench for disco_mem_arbiter: a transaction-level arbitration model
// predicts grants, ack timing and read data; a memory macro model answers the DUT.
module tb_disco_mem_arbiter;

    localparam int AW    = 10;
    localparam int LAT   = 3;
    localparam int SMAX  = 4;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [15:0]   if_rdata;
    logic          if_ack;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [1:0]    ls_be = '0;
    logic [AW-1:0] ls_addr = '0;
    logic [15:0]   ls_wdata = '0;
    logic [15:0]   ls_rdata;
    logic          ls_ack;
    logic          mem_en;
    logic          mem_we;
    logic [1:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          busy;
    logic          owner_ls;

    always #5 clock = ~clock;

    disco_mem_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ack(ls_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner_ls(owner_ls)
    );

    logic [15:0] mem     [DEPTH];
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] rpipe   [LAT+1];
    assign mem_rdata = rpipe[LAT];

    int n_chk = 0, n_err = 0, e = 0;
    // model: current grant (edge, length), next arbitration edge, starvation streak
    int g_s = -100, g_lat = 0, next_samp = 0, streak = 0, rst_edge = -100;
    bit g_ls, g_rd, g_we, g_be00;
    logic [1:0]    g_be;
    logic [AW-1:0] g_addr;
    logic [15:0]   g_wdata, g_data;
    bit            exp_owner;
    logic [15:0]   exp_ifr, exp_lsr;
    bit if_pend, ls_pend, auto_if, auto_ls, auto_rst;
    int p_if = 50, p_ls = 50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, e);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(31));
    endfunction

    // Decide what the coming edge does, from the inputs the DUT is about to sample.
    task automatic predict();
        int s;
        bit pls, pif;
        s = e + 1;
        if (reset) begin
            g_s = -100; g_lat = 0; streak = 0; exp_owner = 0;
            exp_ifr = '0; exp_lsr = '0; next_samp = s + 1; rst_edge = s;
        end else if (s == next_samp) begin
            pls = ls_req && !(if_req && streak == SMAX);
            pif = if_req && !pls;
            if (!if_req) streak = 0;
            if (pls) begin
                if (if_req && streak < SMAX) streak++;
                g_ls = 1; g_we = ls_we; g_rd = !ls_we; g_be = ls_be;
                g_addr = ls_addr; g_wdata = ls_wdata;
                g_be00 = ls_we && (ls_be == 2'b00);
                g_lat = g_be00 ? 1 : (ls_we ? 2 : LAT + 2);
                if (ls_we) begin
                    if (ls_be[0]) ref_mem[ls_addr][7:0]  = ls_wdata[7:0];
                    if (ls_be[1]) ref_mem[ls_addr][15:8] = ls_wdata[15:8];
                end else begin
                    g_data = ref_mem[ls_addr];
                end
            end else if (pif) begin
                streak = 0;
                g_ls = 0; g_we = 0; g_rd = 1; g_be = 2'b11; g_be00 = 0;
                g_addr = if_addr; g_lat = LAT + 2; g_data = ref_mem[if_addr];
            end
            if (pls || pif) begin
                g_s = s; exp_owner = pls; next_samp = s + g_lat + 1;
            end else begin
                next_samp = s + 1;
            end
        end
    endtask

    task automatic check_outputs();
        bit ack_if_m, ack_ls_m, busy_m, men_m;
        ack_if_m = (g_s >= 0) && (e == g_s + g_lat - 1) && !g_ls;
        ack_ls_m = (g_s >= 0) && (e == g_s + g_lat - 1) && g_ls;
        if (g_rd && ack_if_m) exp_ifr = g_data;
        if (g_rd && ack_ls_m) exp_lsr = g_data;
        busy_m = (g_s >= 0) && (e >= g_s) && (e < g_s + g_lat);
        men_m  = (g_s >= 0) && (e == g_s) && !g_be00;
        chk("busy",     32'(busy),     32'(busy_m));
        chk("mem_en",   32'(mem_en),   32'(men_m));
        chk("if_ack",   32'(if_ack),   32'(ack_if_m));
        chk("ls_ack",   32'(ls_ack),   32'(ack_ls_m));
        chk("owner_ls", 32'(owner_ls), 32'(exp_owner));
        chk("if_rdata", 32'(if_rdata), 32'(exp_ifr));
        chk("ls_rdata", 32'(ls_rdata), 32'(exp_lsr));
        if (men_m) begin
            chk("mem_we",   32'(mem_we),   32'(g_we));
            chk("mem_addr", 32'(mem_addr), 32'(g_addr));
            if (g_we || !g_ls) chk("mem_be", 32'(mem_be), 32'(g_be));
            if (g_we) chk("mem_wdata", 32'(mem_wdata), 32'(g_wdata));
        end
        if (e == rst_edge) begin
            chk("rst_mem_we",    32'(mem_we),    32'd0);
            chk("rst_mem_be",    32'(mem_be),    32'd0);
            chk("rst_mem_addr",  32'(mem_addr),  32'd0);
            chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        end
        if (ack_if_m) if_pend = 0;
        if (ack_ls_m) ls_pend = 0;
    endtask

    // Memory macro: read data appears MEM_LAT cycles after the mem_en cycle.
    task automatic mem_macro();
        for (int i = LAT; i > 0; i--) rpipe[i] = rpipe[i-1];
        rpipe[0] = (mem_en && !mem_we) ? mem[mem_addr] : 16'($urandom);
        if (mem_en && mem_we) begin
            if (mem_be[0]) mem[mem_addr][7:0]  = mem_wdata[7:0];
            if (mem_be[1]) mem[mem_addr][15:8] = mem_wdata[15:8];
        end
    endtask

    task automatic drive();
        if (auto_rst) reset = ($urandom_range(199) == 0);
        if (reset) begin
            if_pend = 0; ls_pend = 0;
        end else begin
            if (!if_pend && auto_if && $urandom_range(99) < p_if) begin
                if_pend = 1; if_addr = rand_addr();
            end
            if (!ls_pend && auto_ls && $urandom_range(99) < p_ls) begin
                ls_pend = 1; ls_we = 1'($urandom); ls_be = 2'($urandom);
                ls_addr = rand_addr(); ls_wdata = 16'($urandom);
            end
        end
        if_req = if_pend;
        ls_req = ls_pend;
    endtask

    task automatic step();
        predict();
        @(posedge clock);
        e++;
        @(negedge clock);
        check_outputs();
        mem_macro();
        drive();
    endtask

    task automatic go_if(input logic [AW-1:0] a);
        if_pend = 1; if_addr = a; if_req = 1'b1;
    endtask

    task automatic go_ls(input logic we, input logic [1:0] be, input logic [AW-1:0] a,
                         input logic [15:0] wd);
        ls_pend = 1; ls_we = we; ls_be = be; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
    endtask

    // which: 0 = IF ack, 1 = LS ack, 2 = either
    task automatic wait_ack(input int which, output int n, output bit was_ls);
        bit seen;
        seen = 0; n = 0; was_ls = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            n++;
            if ((which != 0 && ls_ack) || (which != 1 && if_ack)) begin
                seen = 1; was_ls = ls_ack;
            end
        end
        chk("ack_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int n;
        bit wl;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i <= LAT; i++) rpipe[i] = '0;
        mem[16] = 16'hBEEF; ref_mem[16] = 16'hBEEF;
        mem[32] = 16'hFFFF; ref_mem[32] = 16'hFFFF;
        auto_if = 0; auto_ls = 0; auto_rst = 0;

        repeat (3) step();
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_owner", 32'(owner_ls), 32'd0);
        reset = 1'b0;

        go_if(10'h010);
        wait_ack(0, n, wl);
        chk("fetch_lat",  32'(n),        32'(LAT + 2));
        chk("fetch_data", 32'(if_rdata), 32'h0000BEEF);
        step();
        chk("fetch_idle", 32'(busy), 32'd0);

        go_ls(1'b1, 2'b01, 10'h020, 16'h1234);
        wait_ack(1, n, wl);
        chk("store_lat", 32'(n), 32'd2);
        step();
        go_ls(1'b0, 2'b00, 10'h020, 16'h0000);
        wait_ack(1, n, wl);
        chk("load_lat",   32'(n),        32'(LAT + 2));
        chk("load_merge", 32'(ls_rdata), 32'h0000FF34);
        step();

        go_ls(1'b1, 2'b00, 10'h021, 16'hAAAA);
        wait_ack(1, n, wl);
        chk("be0_lat", 32'(n), 32'd1);
        step();

        go_if(10'h010);
        go_ls(1'b0, 2'b11, 10'h020, 16'h0000);
        wait_ack(2, n, wl);
        chk("both_first_ls", 32'(wl),       32'd1);
        chk("both_owner",    32'(owner_ls), 32'd1);
        wait_ack(0, n, wl);
        chk("both_if_gap", 32'(n), 32'(LAT + 3));
        step();

        // Both requesters saturated: IF must win every fifth arbitration.
        auto_if = 1; auto_ls = 1; p_if = 100; p_ls = 100;
        go_if(10'h005);
        go_ls(1'($urandom), 2'($urandom), 10'h006, 16'($urandom));
        for (int k = 0; k < 10; k++) begin
            wait_ack(2, n, wl);
            chk("starve_order", 32'(wl), 32'((k % 5) != 4));
        end
        auto_if = 0; auto_ls = 0;
        for (int i = 0; i < 60 && (if_pend || ls_pend); i++) step();
        step();
        step();

        go_ls(1'b0, 2'b11, 10'h030, 16'h0000);
        step();
        step();
        reset = 1'b1; ls_pend = 0; ls_req = 1'b0;
        step();
        chk("rst_wait_ack",  32'(ls_ack), 32'd0);
        chk("rst_wait_busy", 32'(busy),   32'd0);
        chk("rst_wait_en",   32'(mem_en), 32'd0);
        reset = 1'b0;
        go_if(10'h010);
        wait_ack(0, n, wl);
        chk("post_rst_lat",  32'(n),        32'(LAT + 2));
        chk("post_rst_data", 32'(if_rdata), 32'h0000BEEF);
        step();

        auto_if = 1; auto_ls = 1; auto_rst = 1;
        for (int blk = 0; blk < 8; blk++) begin
            p_if = $urandom_range(10, 100);
            p_ls = $urandom_range(10, 100);
            repeat (200) step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/disco_mem_arbiter.md
Name: disco_mem_arbiter

Overview:
- Shares the single 16-bit-word program/data memory of the disco core between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the core control path and the memory macro.
- Serialises accesses, applies LS-over-IF priority with a starvation guard, and sequences a fixed-latency memory read pipeline.
- Exposes a req/ack handshake per requester.

Parameters:
- ADDR_W, 10, word address width (1024 words).
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..7.
- STARVE_MAX, 4, maximum consecutive LS grants while IF is pending before IF is forced.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  16  fetched word; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse.
- ls_req  in  1  load/store request; held with its fields until ls_ack.
- ls_we  in  1  1=store, 0=load.
- ls_be  in  2  byte enables; bit1=[15:8], bit0=[7:0].
- ls_addr  in  ADDR_W  data word address.
- ls_wdata  in  16  store data.
- ls_rdata  out  16  load data; valid while ls_ack=1.
- ls_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write.
- mem_be  out  2  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  1 whenever state != IDLE.
- owner_ls  out  1  1 when the current or last grant went to LS.

Behaviour:
- Reset is synchronous, active-high, and takes effect even mid-operation.
  - All outputs go to 0 and the FSM goes to IDLE; the starvation counter is cleared.
  - Any in-flight read is discarded and no ack is issued for it.
  - Requesters must re-issue after reset.
- All memory-side outputs and acks are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: on each edge, sample requests.
  - No request: stay in IDLE.
  - LS only: grant LS.
  - IF only: grant IF.
  - Both: grant LS unless streak==STARVE_MAX, in which case grant IF.
  - On a grant, latch the command into mem_* registers and go to ISSUE.
- ISSUE: mem_en=1 for exactly this one cycle.
  - IF grants drive mem_we=0, mem_be=2'b11.
  - Store: go to RESP.
  - Load or fetch: load the latency counter with MEM_LAT-1 and go to WAIT.
- WAIT: counter decrements each cycle. When the counter is 0, capture mem_rdata into the granted requester's rdata register and go to RESP.
- RESP: the granted requester's ack=1 for one cycle; then go to IDLE.
  - Requests are not sampled in RESP, so a requester that drops req right after ack is never double-granted.
- Latency from the req-sampling edge to the ack cycle:
  - Read or fetch: MEM_LAT+2 cycles.
  - Store: 2 cycles.
  - Throughput is one access per MEM_LAT+3 cycles (reads) or 3 cycles (stores).
- Store with ls_be=2'b00: no memory access (mem_en stays 0). FSM goes IDLE→RESP directly and ls_ack still pulses.
- rdata registers hold their last captured value between acks. Only the granted requester's rdata changes.
- Starvation counter streak (3 bits):
  - Increments on each LS grant made while if_req=1.
  - Clears on any IF grant, and on any IDLE sample with if_req=0.
  - Saturates at STARVE_MAX.
- owner_ls updates at grant time and holds until the next grant.
- A req that drops before ack is a protocol violation. The access still completes and ack still pulses.
- ls_be is ignored for loads; the full word is returned.

Test Plan:
- MEM_LAT=1, mem[0x010]=0xBEEF; if_req with if_addr=0x010 sampled at edge 0 → mem_en at cycle 1; if_ack=1 with if_rdata=0xBEEF at cycle 3; busy=0 at cycle 4.
- Store with ls_addr=0x020, ls_wdata=0x1234, ls_be=2'b01 → mem_en=1, mem_we=1, mem_be=01 in cycle 1; ls_ack at cycle 2. A following load of 0x020 from initial 0xFFFF returns 0xFF34.
- if_req and ls_req held continuously with ls_req re-asserted immediately after each ack, STARVE_MAX=4 → grant order LS,LS,LS,LS,IF,LS…; the IF grant occurs on the 5th arbitration.
- Both requests raised in the same cycle with streak=0 → LS granted first (owner_ls=1); IF is acked MEM_LAT+3 cycles after ls_ack.
- reset asserted during WAIT of a load with MEM_LAT=4 → no ls_ack, all outputs 0 next cycle, busy=0. A new IF request after reset completes normally in 6 cycles.
- Store with ls_be=2'b00 → mem_en stays 0 throughout; ls_ack pulses at cycle 1 after the sampling edge.
